// File: rtl/count_sweep_ctrl.sv
// Triangle sweep counter: ramps lo -> hi -> lo for a programmed number of round trips.
// Bounds are captured when a start is accepted. All state updates on the falling edge of clk.
module count_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [3:0]       loops,
    output logic [WIDTH-1:0] out,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t           state;
    logic [WIDTH-1:0] lo_l;
    logic [WIDTH-1:0] hi_l;
    logic [3:0]       loops_l;
    logic [3:0]       trips;
    logic             final_trip;

    // loops_l == 0 means run forever, so the final trip is never reached.
    assign final_trip = (loops_l != 4'd0) && ((trips + 4'd1) == loops_l);
    assign busy       = (state != IDLE);

    always_ff @(negedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out     <= '0;
            dir     <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            trips   <= '0;
            lo_l    <= '0;
            hi_l    <= '0;
            loops_l <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (lo >= hi) begin
                            err <= 1'b1;
                        end else begin
                            lo_l    <= lo;
                            hi_l    <= hi;
                            loops_l <= loops;
                            out     <= lo;
                            dir     <= 1'b1;
                            trips   <= '0;
                            state   <= UP;
                        end
                    end
                end
                UP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (!pause) begin
                        if (out != hi_l) begin
                            out <= out + 1'b1;
                        end else begin
                            // Turn around without repeating the endpoint.
                            out   <= hi_l - 1'b1;
                            dir   <= 1'b0;
                            state <= DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (!pause) begin
                        if (out != lo_l) begin
                            out <= out - 1'b1;
                        end else if (final_trip) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            dir   <= 1'b1;
                        end else begin
                            if (loops_l != 4'd0) trips <= trips + 4'd1;
                            out   <= lo_l + 1'b1;
                            dir   <= 1'b1;
                            state <= UP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Bench for count_sweep_ctrl: directed scenarios plus random sessions, each cycle
// compared with a model that derives the output from the step count inside a sweep.
module tb_count_sweep_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, start, pause, abort;
    logic [W-1:0] lo, hi;
    logic [3:0]   loops;
    logic [W-1:0] out;
    logic         dir, busy, done, err;

    int errors = 0;
    int checks = 0;

    // model state: k = number of steps taken since the accepted start
    int           m_lo, m_hi, m_loops, m_k;
    logic [W-1:0] m_out;
    logic         m_dir, m_busy, m_done, m_err;

    count_sweep_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .lo(lo), .hi(hi), .loops(loops),
        .out(out), .dir(dir), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void model_step();
        int span, r;
        if (rst) begin
            m_busy = 0; m_out = '0; m_dir = 1; m_done = 0; m_err = 0;
            m_lo = 0; m_hi = 0; m_loops = 0; m_k = 0;
            return;
        end
        m_done = 0;
        m_err  = 0;
        if (!m_busy) begin
            if (start) begin
                if (int'(lo) >= int'(hi)) begin
                    m_err = 1;
                end else begin
                    m_lo = int'(lo); m_hi = int'(hi); m_loops = int'(loops);
                    m_k = 0; m_busy = 1; m_out = lo; m_dir = 1;
                end
            end
        end else if (abort) begin
            m_busy = 0;
        end else if (!pause) begin
            span = m_hi - m_lo;
            if (m_loops != 0 && m_k == 2 * span * m_loops) begin
                m_busy = 0; m_done = 1; m_out = W'(m_lo); m_dir = 1;
            end else begin
                m_k++;
                r = m_k % (2 * span);
                m_out = (r <= span) ? W'(m_lo + r) : W'(m_lo + 2 * span - r);
                m_dir = (r >= 1 && r <= span) ? 1'b1 : 1'b0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        chk("out", 32'(out), 32'(m_out));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic launch(input int l, input int h, input int n);
        lo = W'(l); hi = W'(h); loops = 4'(n); start = 1;
        cyc();
        start = 0;
    endtask

    initial begin
        int len;
        rst = 1; start = 0; pause = 0; abort = 0; lo = '0; hi = '0; loops = '0;
        m_busy = 0; m_out = '0; m_dir = 1; m_done = 0; m_err = 0;
        m_lo = 0; m_hi = 0; m_loops = 0; m_k = 0;
        @(posedge clk);
        repeat (2) cyc();
        rst = 0;
        repeat (3) cyc();

        // basic single trip 2..5..2
        launch(2, 5, 1);
        repeat (9) cyc();

        // rejected starts: equal bounds and inverted bounds
        launch(5, 5, 1);
        cyc();
        launch(7, 3, 2);
        repeat (2) cyc();

        // full-range endless sweep, then abort
        launch(0, 15, 0);
        repeat (70) cyc();
        abort = 1; cyc(); abort = 0;
        repeat (3) cyc();

        // abort while idle is ignored, start in the same cycle is processed
        abort = 1;
        launch(1, 3, 2);
        abort = 0;
        repeat (2) cyc();
        pause = 1; repeat (3) cyc(); pause = 0;
        repeat (9) cyc();

        // reset mid-sweep on the way down, then a minimal sweep
        launch(2, 6, 1);
        repeat (6) cyc();
        rst = 1; cyc(); rst = 0;
        cyc();
        launch(0, 1, 1);
        repeat (4) cyc();

        // start held and inputs changed while busy
        launch(3, 6, 2);
        start = 1;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) begin hi = 4'd9; lo = 4'd0; loops = 4'd5; end
            cyc();
        end
        start = 0;
        repeat (4) cyc();

        // random sessions
        for (int s = 0; s < 40; s++) begin
            launch($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
            len = $urandom_range(5, 60);
            for (int i = 0; i < len; i++) begin
                pause = ($urandom_range(0, 4) == 0);
                abort = ($urandom_range(0, 40) == 0);
                start = ($urandom_range(0, 7) == 0);
                rst   = ($urandom_range(0, 150) == 0);
                if ($urandom_range(0, 9) == 0) begin
                    lo = W'($urandom); hi = W'($urandom); loops = 4'($urandom_range(0, 3));
                end
                cyc();
            end
            pause = 0; start = 0; rst = 0; abort = 1;
            cyc();
            abort = 0;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
